// File: rtl/code_entry.sv
// Keypad front end of the six-digit lock: collects digits, holds the stored code, runs unlock/change/lockout.
// Latency: all outputs registered; a key affects outputs on the cycle after its strobe; CHECK lasts one cycle.
// Backpressure: none; one key per cycle is consumed or dropped depending on state.
module code_entry #(
  parameter logic [23:0] INIT_CODE   = 24'h123456,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCK_CYCLES = 1000,
  parameter int          OPEN_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        match,
  output logic [23:0] entry,
  output logic [23:0] stored,
  output logic        check,
  output logic [2:0]  count,
  output logic        unlock,
  output logic        alarm,
  output logic        saved,
  output logic [2:0]  fail_cnt
);

  localparam int TMAX = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {S_ENTRY, S_CHECK, S_OPEN, S_NEWCODE, S_LOCKED} state_t;

  state_t        r_state, w_state_nxt;
  logic [23:0]   r_entry, w_entry_nxt, w_ed_entry;
  logic [2:0]    r_count, w_count_nxt, w_ed_count;
  logic [23:0]   r_stored, w_stored_nxt;
  logic [2:0]    r_fail, w_fail_nxt;
  logic          r_saved, w_saved_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;

  logic       w_key_digit, w_key_bs, w_key_clr, w_key_ent, w_key_chg;
  logic [2:0] w_fail_inc;
  logic       w_fail_lock;

  assign w_key_digit = key_valid && (key_code <= 4'd9);
  assign w_key_bs    = key_valid && (key_code == 4'hA);
  assign w_key_clr   = key_valid && (key_code == 4'hB);
  assign w_key_ent   = key_valid && (key_code == 4'hC);
  assign w_key_chg   = key_valid && (key_code == 4'hD);

  // A mismatch (or short enter) bumps the counter; reaching the limit diverts into lockout.
  assign w_fail_inc  = r_fail + 3'd1;
  assign w_fail_lock = (w_fail_inc == 3'(MAX_FAIL));

  // Digit-editing result for the current key, used only by the states that collect digits.
  always_comb begin
    w_ed_entry = r_entry;
    w_ed_count = r_count;
    if (w_key_digit && (r_count < 3'd6)) begin
      for (int i = 0; i < 6; i++) begin
        if (r_count == 3'(i)) w_ed_entry[23-4*i -: 4] = key_code;
      end
      w_ed_count = r_count + 3'd1;
    end else if (w_key_bs && (r_count != 3'd0)) begin
      for (int i = 0; i < 6; i++) begin
        if (r_count == 3'(i + 1)) w_ed_entry[23-4*i -: 4] = 4'h0;
      end
      w_ed_count = r_count - 3'd1;
    end else if (w_key_clr) begin
      w_ed_entry = '0;
      w_ed_count = 3'd0;
    end
  end

  // Next-state and next-register values; the free-running decrement is harmless outside OPEN/LOCKED.
  always_comb begin
    w_state_nxt  = r_state;
    w_entry_nxt  = r_entry;
    w_count_nxt  = r_count;
    w_stored_nxt = r_stored;
    w_fail_nxt   = r_fail;
    w_saved_nxt  = 1'b0;
    w_timer_nxt  = (r_timer != '0) ? (r_timer - TW'(1)) : r_timer;
    case (r_state)
      S_ENTRY: begin
        if (w_key_ent) begin
          if (r_count == 3'd6) begin
            w_state_nxt = S_CHECK;
          end else begin
            w_fail_nxt  = w_fail_inc;
            w_entry_nxt = '0;
            w_count_nxt = 3'd0;
            if (w_fail_lock) begin
              w_state_nxt = S_LOCKED;
              w_timer_nxt = TW'(LOCK_CYCLES - 1);
            end
          end
        end else begin
          w_entry_nxt = w_ed_entry;
          w_count_nxt = w_ed_count;
        end
      end
      S_CHECK: begin
        w_entry_nxt = '0;
        w_count_nxt = 3'd0;
        if (match) begin
          w_state_nxt = S_OPEN;
          w_fail_nxt  = 3'd0;
          w_timer_nxt = TW'(OPEN_CYCLES - 1);
        end else begin
          w_fail_nxt = w_fail_inc;
          if (w_fail_lock) begin
            w_state_nxt = S_LOCKED;
            w_timer_nxt = TW'(LOCK_CYCLES - 1);
          end else begin
            w_state_nxt = S_ENTRY;
          end
        end
      end
      S_OPEN: begin
        // Expiry wins over any key pressed in the same cycle.
        if (r_timer == '0)              w_state_nxt = S_ENTRY;
        else if (w_key_chg)             w_state_nxt = S_NEWCODE;
        else if (w_key_clr || w_key_ent) w_state_nxt = S_ENTRY;
      end
      S_NEWCODE: begin
        if (w_key_ent && (r_count == 3'd6)) begin
          w_stored_nxt = r_entry;
          w_saved_nxt  = 1'b1;
          w_entry_nxt  = '0;
          w_count_nxt  = 3'd0;
          w_state_nxt  = S_ENTRY;
        end else if (w_key_clr && (r_count == 3'd0)) begin
          w_state_nxt = S_ENTRY;
        end else begin
          w_entry_nxt = w_ed_entry;
          w_count_nxt = w_ed_count;
        end
      end
      S_LOCKED: begin
        if (r_timer == '0) begin
          w_fail_nxt  = 3'd0;
          w_state_nxt = S_ENTRY;
        end
      end
      default: w_state_nxt = S_ENTRY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_ENTRY;
    else        r_state <= w_state_nxt;
  end

  // Datapath registers; the stored code falls back to the factory value on any reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry  <= '0;
      r_count  <= 3'd0;
      r_stored <= INIT_CODE;
      r_fail   <= 3'd0;
      r_saved  <= 1'b0;
      r_timer  <= '0;
    end else begin
      r_entry  <= w_entry_nxt;
      r_count  <= w_count_nxt;
      r_stored <= w_stored_nxt;
      r_fail   <= w_fail_nxt;
      r_saved  <= w_saved_nxt;
      r_timer  <= w_timer_nxt;
    end
  end

  assign entry    = r_entry;
  assign stored   = r_stored;
  assign count    = r_count;
  assign fail_cnt = r_fail;
  assign saved    = r_saved;
  assign check    = (r_state == S_CHECK);
  assign unlock   = (r_state == S_OPEN) || (r_state == S_NEWCODE);
  assign alarm    = (r_state == S_LOCKED);

endmodule

// File: doc/code_entry.md
Name: code_entry

Overview:
- Keypad-side front end of the six-digit electronic lock: collects typed digits, holds the stored code, and drives the combinational digit comparator.
- Packs the typed and stored codes onto the comparator's six-digit buses, pulses its enable, and samples its single-bit match result.
- Owns the lock state: unlock, code change, failed-attempt counting and lockout alarm.

Parameters:
- INIT_CODE, 24'h123456, stored code after reset; digit 1 in [23:20], digit 6 in [3:0], BCD.
- MAX_FAIL, 3, consecutive mismatches that trigger lockout (1..7).
- LOCK_CYCLES, 1000, clk cycles spent in LOCKED.
- OPEN_CYCLES, 5000, clk cycles before OPEN automatically relocks.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe, key_code is valid.
- key_code  in  4  0-9 digit; 4'hA backspace; 4'hB clear; 4'hC enter; 4'hD change code; 4'hE/4'hF ignored.
- match  in  1  comparator result (1 = codes equal), sampled only in CHECK.
- entry  out  24  typed digits, digit 1 in [23:20], to comparator a-side.
- stored  out  24  stored code, same packing, to comparator b-side.
- check  out  1  comparator enable, high exactly during CHECK.
- count  out  3  digits typed so far, 0..6.
- unlock  out  1  high in OPEN.
- alarm  out  1  high in LOCKED.
- saved  out  1  one-cycle pulse when a new code is committed.
- fail_cnt  out  3  consecutive mismatches.

Behaviour:
- Reset (async assert, sync release): state ENTRY; entry=0, count=0, stored=INIT_CODE; check, unlock, alarm, saved=0; fail_cnt=0; timers 0.
- States: ENTRY, CHECK, OPEN, NEW_CODE, LOCKED.
- Digit entry (ENTRY and NEW_CODE):
  - Digit with count<6: written to slot count+1 (first digit to [23:20]), count++.
  - Digit with count==6: ignored.
  - Backspace with count>0: slot count cleared to 0, count--. With count==0: no-op.
  - Clear: entry=0, count=0.
- Key handling in other states: keys ignored in CHECK and LOCKED. Only one key is processed per cycle.
- ENTRY:
  - Enter with count==6 -> CHECK.
  - Enter with count<6 -> failure path (below), no CHECK.
  - 4'hD -> ignored.
- CHECK, lasts exactly 1 cycle:
  - check=1; match is sampled at the end of that cycle.
  - match=1 -> OPEN; fail_cnt=0; entry and count cleared.
  - match=0 -> failure path.
- Failure path:
  - fail_cnt+1; entry and count cleared.
  - New fail_cnt==MAX_FAIL -> LOCKED, timer loaded with LOCK_CYCLES-1.
  - Otherwise -> ENTRY.
- OPEN:
  - unlock=1; timer counts down from OPEN_CYCLES-1.
  - Clear, enter, or timer==0 -> ENTRY with unlock=0 on the next cycle.
  - 4'hD -> NEW_CODE.
  - Digits and backspace ignored.
- NEW_CODE:
  - unlock stays 1; digits are collected into entry.
  - Enter with count==6: stored<=entry, saved pulses for 1 cycle, entry and count cleared -> ENTRY.
  - Enter with count<6: ignored.
  - Clear with count==0: abort -> ENTRY with stored unchanged.
  - Clear with count>0: normal clear only.
- LOCKED:
  - alarm=1; timer counts down.
  - At 0: fail_cnt=0, alarm=0 -> ENTRY.
- Outputs are registered; check, unlock and alarm are decoded from the state register with no extra latency.
- Reset mid-operation (any state, including CHECK or mid-NEW_CODE): immediate return to reset values; stored reverts to INIT_CODE.
- Timer width is ceil(log2(max(LOCK_CYCLES, OPEN_CYCLES))).
- Timers are reset only on state entry.

Test Plan:
- Reset, type 1,2,3,4,5,6, enter; match=1 in CHECK -> check high 1 cycle, unlock=1 next cycle, entry=0, count=0, fail_cnt=0.
- Type 9,8,7,6,5,4, enter with match=0, three times (MAX_FAIL=3) -> fail_cnt 1,2, then alarm=1 for exactly LOCK_CYCLES cycles; keys during LOCKED ignored; then ENTRY with fail_cnt=0.
- Type 1,2,3, backspace, 7, then 7 more digits -> entry=24'h127xxx with only 6 digits kept; count=6; 7th digit ignored.
- In OPEN, press D, type 6,5,4,3,2,1, enter -> saved pulses once, stored=24'h654321, unlock=0.
- In OPEN, leave idle for OPEN_CYCLES cycles -> unlock falls, state ENTRY.
- Enter with count=4 -> no check pulse, fail_cnt=1. Assert rst_n=0 during CHECK -> all outputs return to reset values asynchronously.
